// File: rtl/frog_controller.sv
// Frog position, hop, death/respawn, lives and score controller.
// Advances one step per frame_clk edge; all outputs are registered.
module frog_controller #(
  parameter logic [10:0] START_X      = 11'd320,
  parameter logic [10:0] START_Y      = 11'd440,
  parameter logic [10:0] STEP         = 11'd40,
  parameter logic [10:0] X_MAX        = 11'd600,
  parameter logic [10:0] Y_MAX        = 11'd440,
  parameter logic [10:0] GOAL_Y       = 11'd0,
  parameter logic [3:0]  HOP_FRAMES   = 4'd4,
  parameter logic [5:0]  DEATH_FRAMES = 6'd30,
  parameter logic [1:0]  START_LIVES  = 2'd3
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [7:0]  keycode,
  input  logic        Collision,
  output logic [10:0] Frog_X,
  output logic [10:0] Frog_Y,
  output logic [1:0]  Lives,
  output logic [7:0]  Score,
  output logic        Frog_Dead,
  output logic        Game_Over
);

  typedef enum logic [1:0] {
    ALIVE, COOLDOWN, DEAD, GAME_OVER
  } state_e;

  localparam logic [7:0] K_UP = 8'h1A;
  localparam logic [7:0] K_DN = 8'h16;
  localparam logic [7:0] K_LT = 8'h04;
  localparam logic [7:0] K_RT = 8'h07;

  localparam logic [5:0] HOP_LAST = 6'(HOP_FRAMES - 4'd1);
  localparam logic [5:0] DIE_LAST = DEATH_FRAMES - 6'd1;

  state_e      state_q;
  logic [5:0]  timer_q;
  logic [7:0]  last_key_q;
  logic [10:0] x_q, y_q;
  logic [1:0]  lives_q;
  logic [7:0]  score_q;
  logic        dead_q, over_q;

  logic        key_new;
  logic        hop_up, hop_dn, hop_lt, hop_rt, hop;
  logic        goal;
  logic [10:0] y_up, y_dn, x_lt, x_rt;

  assign y_up = y_q - STEP;
  assign y_dn = y_q + STEP;
  assign x_lt = x_q - STEP;
  assign x_rt = x_q + STEP;

  // Bounds are tested before the update so no move can wrap.
  assign key_new = keycode != last_key_q;
  assign hop_up  = key_new && keycode == K_UP && y_q >= STEP;
  assign hop_dn  = key_new && keycode == K_DN && y_dn <= Y_MAX;
  assign hop_lt  = key_new && keycode == K_LT && x_q >= STEP;
  assign hop_rt  = key_new && keycode == K_RT && x_rt <= X_MAX;
  assign hop     = hop_up | hop_dn | hop_lt | hop_rt;
  assign goal    = hop_up && y_up == GOAL_Y;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ALIVE;
      timer_q    <= '0;
      last_key_q <= 8'h00;
      x_q        <= START_X;
      y_q        <= START_Y;
      lives_q    <= START_LIVES;
      score_q    <= '0;
      dead_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      last_key_q <= keycode;
      unique case (state_q)
        ALIVE: begin
          if (Collision) begin
            state_q <= DEAD;
            dead_q  <= 1'b1;
            timer_q <= '0;
            lives_q <= lives_q - 2'd1;
          end else if (hop) begin
            state_q <= COOLDOWN;
            timer_q <= '0;
            if (goal) begin
              x_q <= START_X;
              y_q <= START_Y;
              if (score_q != 8'hFF)
                score_q <= score_q + 8'd1;
            end else begin
              unique case (1'b1)
                hop_up: y_q <= y_up;
                hop_dn: y_q <= y_dn;
                hop_lt: x_q <= x_lt;
                hop_rt: x_q <= x_rt;
                default: ;
              endcase
            end
          end
        end
        COOLDOWN: begin
          if (Collision) begin
            state_q <= DEAD;
            dead_q  <= 1'b1;
            timer_q <= '0;
            lives_q <= lives_q - 2'd1;
          end else if (timer_q == HOP_LAST) begin
            state_q <= ALIVE;
          end else begin
            timer_q <= timer_q + 6'd1;
          end
        end
        DEAD: begin
          if (timer_q == DIE_LAST) begin
            dead_q <= 1'b0;
            if (lives_q == 2'd0) begin
              state_q <= GAME_OVER;
              over_q  <= 1'b1;
            end else begin
              state_q <= ALIVE;
              x_q     <= START_X;
              y_q     <= START_Y;
            end
          end else begin
            timer_q <= timer_q + 6'd1;
          end
        end
        GAME_OVER: ;
        default: state_q <= ALIVE;
      endcase
    end
  end

  assign Frog_X    = x_q;
  assign Frog_Y    = y_q;
  assign Lives     = lives_q;
  assign Score     = score_q;
  assign Frog_Dead = dead_q;
  assign Game_Over = over_q;

endmodule

// File: tb/tb_frog_controller.sv
// Directed bench for frog_controller: hops, bounds, cooldown, goal,
// death/respawn, game over and asynchronous reset.
module tb_frog_controller;

  logic        frame_clk = 1'b0;
  logic        Reset;
  logic [7:0]  keycode;
  logic        Collision;
  logic [10:0] Frog_X, Frog_Y;
  logic [1:0]  Lives;
  logic [7:0]  Score;
  logic        Frog_Dead, Game_Over;

  int total = 0;
  int bad   = 0;

  frog_controller dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .Collision (Collision),
    .Frog_X    (Frog_X),
    .Frog_Y    (Frog_Y),
    .Lives     (Lives),
    .Score     (Score),
    .Frog_Dead (Frog_Dead),
    .Game_Over (Game_Over)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Press once, release, and sit out the cooldown so the FSM is ALIVE.
  task automatic hop(input logic [7:0] k);
    keycode = k;
    tick();
    keycode = 8'h00;
    repeat (4) tick();
  endtask

  initial begin
    Reset = 1'b1;
    keycode = 8'h00;
    Collision = 1'b0;
    #12;
    chk("rst_x", Frog_X, 320);
    chk("rst_y", Frog_Y, 440);
    chk("rst_lives", Lives, 3);
    chk("rst_score", Score, 0);
    chk("rst_dead", Frog_Dead, 0);
    chk("rst_over", Game_Over, 0);
    @(negedge frame_clk);
    Reset = 1'b0;
    tick();

    // held up key hops once
    keycode = 8'h1A;
    tick();
    chk("up_first", Frog_Y, 400);
    repeat (9) tick();
    chk("up_held_y", Frog_Y, 400);
    chk("up_held_x", Frog_X, 320);
    keycode = 8'h00;
    tick();

    hop(8'h16);
    chk("down_back", Frog_Y, 440);
    keycode = 8'h16;
    tick();
    chk("down_bound", Frog_Y, 440);
    keycode = 8'h00;
    tick();
    keycode = 8'h07;
    tick();
    chk("no_cooldown", Frog_X, 360);
    keycode = 8'h00;
    repeat (4) tick();

    for (int i = 0; i < 9; i++) hop(8'h04);
    chk("walk_left", Frog_X, 0);
    keycode = 8'h04;
    tick();
    chk("left_bound", Frog_X, 0);
    chk("left_bound_y", Frog_Y, 440);

    // toggled right key: cooldown blocks presses for 4 edges
    keycode = 8'h07; tick();
    chk("rt_e1", Frog_X, 40);
    keycode = 8'h00; tick();
    keycode = 8'h07; tick();
    chk("rt_e3", Frog_X, 40);
    keycode = 8'h00; tick();
    keycode = 8'h00; tick();
    chk("rt_e5", Frog_X, 40);
    keycode = 8'h07; tick();
    chk("rt_e6", Frog_X, 80);
    keycode = 8'h00;
    repeat (4) tick();

    for (int i = 0; i < 10; i++) hop(8'h1A);
    chk("climb_y", Frog_Y, 40);
    chk("climb_score", Score, 0);
    keycode = 8'h1A;
    tick();
    chk("goal_x", Frog_X, 320);
    chk("goal_y", Frog_Y, 440);
    chk("goal_score", Score, 1);
    keycode = 8'h00;
    repeat (4) tick();

    // collision beats a same-edge hop
    hop(8'h1A);
    chk("pre_die_y", Frog_Y, 400);
    Collision = 1'b1;
    keycode = 8'h1A;
    tick();
    chk("die1_y", Frog_Y, 400);
    chk("die1_lives", Lives, 2);
    chk("die1_dead", Frog_Dead, 1);
    Collision = 1'b0;
    keycode = 8'h00;
    repeat (10) tick();
    Collision = 1'b1;
    tick();
    Collision = 1'b0;
    chk("dead_ignore_col", Lives, 2);
    repeat (18) tick();
    chk("dead_last", Frog_Dead, 1);
    chk("dead_frozen_y", Frog_Y, 400);
    tick();
    chk("respawn_dead", Frog_Dead, 0);
    chk("respawn_x", Frog_X, 320);
    chk("respawn_y", Frog_Y, 440);

    Collision = 1'b1;
    tick();
    Collision = 1'b0;
    chk("die2_lives", Lives, 1);
    repeat (30) tick();
    chk("die2_dead", Frog_Dead, 0);
    chk("die2_over", Game_Over, 0);
    Collision = 1'b1;
    tick();
    Collision = 1'b0;
    chk("die3_lives", Lives, 0);
    chk("die3_dead", Frog_Dead, 1);
    repeat (29) tick();
    chk("die3_not_over", Game_Over, 0);
    tick();
    chk("over", Game_Over, 1);
    chk("over_dead", Frog_Dead, 0);
    chk("over_score", Score, 1);
    keycode = 8'h07;
    Collision = 1'b1;
    repeat (3) tick();
    chk("over_hold_x", Frog_X, 320);
    chk("over_hold_l", Lives, 0);
    chk("over_hold_o", Game_Over, 1);
    Collision = 1'b0;
    keycode = 8'h00;

    #2 Reset = 1'b1;
    #1;
    chk("rst_go_over", Game_Over, 0);
    chk("rst_go_score", Score, 0);
    chk("rst_go_lives", Lives, 3);
    @(negedge frame_clk);
    Reset = 1'b0;
    tick();

    hop(8'h1A);
    Collision = 1'b1;
    tick();
    Collision = 1'b0;
    repeat (10) tick();
    chk("mid_dead", Frog_Dead, 1);
    #2 Reset = 1'b1;
    #1;
    chk("rst_mid_y", Frog_Y, 440);
    chk("rst_mid_lives", Lives, 3);
    chk("rst_mid_dead", Frog_Dead, 0);
    @(negedge frame_clk);
    Reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
